// File: rtl/sram_rd_streamer.sv
// sram_rd_streamer: reads a block of consecutive words from a single-port SRAM
// with a one-cycle registered read and streams them out over a valid/ready port.
// A 3-entry skid FIFO absorbs the read pipeline, so issuing reads never depends
// combinationally on the consumer's ready.
module sram_rd_streamer #(
    parameter int unsigned DATA_LEN = 32,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned ADDR_LEN = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_LEN-1:0] start_addr,
    input  logic [ADDR_LEN:0]   length,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                ren,
    output logic [ADDR_LEN-1:0] rd_addr,
    input  logic [DATA_LEN-1:0] rd_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATA_LEN-1:0] m_data
);

    localparam int unsigned CntW = ADDR_LEN + 1;

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e              state_q, state_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic [CntW-1:0]     len_q, len_d;
    logic [CntW-1:0]     issued_q, issued_d;
    logic [CntW-1:0]     sent_q, sent_d;
    logic                inflight_q;
    logic                fifo_clr;

    logic [DATA_LEN-1:0] fifo_mem_q [3];
    logic [1:0]          wr_ptr_q, rd_ptr_q, count_q;
    logic                push, pop;
    logic [2:0]          outstanding;

    // Words already buffered plus the one read possibly still in the SRAM pipe.
    assign outstanding = {1'b0, count_q} + {2'b00, inflight_q};

    assign busy    = (state_q == StRun);
    assign done    = (state_q == StFin);
    assign ren     = (state_q == StRun) && (issued_q < len_q) && (outstanding < 3'd3);
    assign rd_addr = addr_q;
    assign m_valid = (count_q != 2'd0);
    assign m_data  = fifo_mem_q[rd_ptr_q];
    assign push    = inflight_q;
    assign pop     = m_valid && m_ready;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Next-state: command capture, read issue bookkeeping, completion and abort.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        issued_d = issued_q;
        sent_d   = sent_q;
        fifo_clr = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d   = start_addr;
                    len_d    = length;
                    issued_d = '0;
                    sent_d   = '0;
                    state_d  = (length == '0) ? StFin : StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    // Drop buffered words; clearing inflight discards the pending read.
                    fifo_clr = 1'b1;
                    state_d  = StIdle;
                end else begin
                    if (ren) begin
                        addr_d   = (addr_q == ADDR_LEN'(DEPTH - 1)) ? '0 : addr_q + ADDR_LEN'(1);
                        issued_d = issued_q + CntW'(1);
                    end
                    if (pop) begin
                        sent_d = sent_q + CntW'(1);
                        if (sent_q == len_q - CntW'(1)) begin
                            state_d = StFin;
                        end
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            sent_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            sent_q     <= sent_d;
            inflight_q <= ren && !fifo_clr;
        end
    end

    // Output FIFO: captures SRAM data one cycle after each read, pops on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                fifo_mem_q[i] <= '0;
            end
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 2'd0;
        end else if (fifo_clr) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= rd_data;
                wr_ptr_q             <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_rd_streamer.sv
// Bench for sram_rd_streamer: SRAM model, cycle-level reference model with a
// per-cycle compare process, and directed commands with literal expectations.
module tb_sram_rd_streamer;

    localparam int DATA_LEN = 32;
    localparam int DEPTH    = 1024;
    localparam int ADDR_LEN = 10;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                start = 1'b0;
    logic [ADDR_LEN-1:0] start_addr = '0;
    logic [ADDR_LEN:0]   length = '0;
    logic                abort = 1'b0;
    logic                busy, done, ren, m_valid;
    logic [ADDR_LEN-1:0] rd_addr;
    logic [DATA_LEN-1:0] rd_data = '0;
    logic                m_ready = 1'b1;
    logic [DATA_LEN-1:0] m_data;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    sram_rd_streamer #(
        .DATA_LEN(DATA_LEN),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .start_addr(start_addr),
        .length    (length),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .ren       (ren),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word_at(input int a);
        return 32'hD000_0007 + (32'(a) << 8);
    endfunction

    // SRAM with registered read port
    always @(posedge clk) if (ren) rd_data <= word_at(int'(rd_addr));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model state and per-command statistics
    typedef enum {MIdle, MRun, MFin} mstate_e;
    mstate_e     mstate = MIdle;
    logic [31:0] exp_data [$];
    int          ready_q [$];
    int          m_start, m_len, st_issued, st_xfer, start_cyc;
    int          ren_n, first_ren, last_ren, val_n, first_val, last_val;
    int          done_n, done_at, busy_seen, max_out;
    int          addr_log [4];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        exp_ren, exp_valid, xfer;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_ren", ren, 0);
            check("rst_rd_addr", rd_addr, 0);
            check("rst_m_valid", m_valid, 0);
            check("rst_m_data", m_data, 0);
            mstate = MIdle;
            exp_data.delete();
            ready_q.delete();
            prev_stall = 1'b0;
        end else begin
            check("busy", busy, mstate == MRun);
            check("done", done, mstate == MFin);
            if (busy) busy_seen++;
            if (done) begin
                done_n++;
                done_at = cyc - start_cyc;
            end
            exp_ren = (mstate == MRun) && (st_issued < m_len) && (st_issued - st_xfer < 3);
            check("ren", ren, exp_ren);
            if (ren) begin
                if (ren_n == 0) first_ren = cyc - start_cyc;
                last_ren = cyc - start_cyc;
                if (ren_n < 4) addr_log[ren_n] = int'(rd_addr);
                ren_n++;
            end
            if (exp_ren) begin
                check("rd_addr", rd_addr, (m_start + st_issued) % DEPTH);
                exp_data.push_back(word_at((m_start + st_issued) % DEPTH));
                ready_q.push_back(cyc + 2);
                st_issued++;
            end
            exp_valid = (ready_q.size() > 0) && (ready_q[0] <= cyc);
            check("m_valid", m_valid, exp_valid);
            if (m_valid) begin
                if (val_n == 0) first_val = cyc - start_cyc;
                last_val = cyc - start_cyc;
                val_n++;
            end
            if (exp_valid) check("m_data", m_data, exp_data[0]);
            if (prev_stall) check("m_data_stable", m_data, prev_data);
            xfer       = exp_valid && m_ready;
            prev_stall = exp_valid && !m_ready;
            if (exp_valid) prev_data = exp_data[0];
            if (xfer) begin
                void'(exp_data.pop_front());
                void'(ready_q.pop_front());
                st_xfer++;
            end
            if (st_issued - st_xfer > max_out) max_out = st_issued - st_xfer;
            case (mstate)
                MIdle: if (start) begin
                    m_start = int'(start_addr); m_len = int'(length);
                    st_issued = 0; st_xfer = 0; start_cyc = cyc;
                    ren_n = 0; first_ren = -1; last_ren = -1;
                    val_n = 0; first_val = -1; last_val = -1;
                    done_n = 0; done_at = -1; busy_seen = 0; max_out = 0;
                    for (int i = 0; i < 4; i++) addr_log[i] = -1;
                    mstate = (length == 0) ? MFin : MRun;
                end
                MRun: if (abort) begin
                    exp_data.delete();
                    ready_q.delete();
                    prev_stall = 1'b0;
                    mstate = MIdle;
                end else if (xfer && st_xfer == m_len) begin
                    mstate = MFin;
                end
                default: mstate = MIdle;
            endcase
        end
    end

    task automatic do_start(input int a, input int l);
        @(posedge clk); #1;
        start = 1'b1; start_addr = ADDR_LEN'(a); length = (ADDR_LEN+1)'(l);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(posedge clk); #2;
            if (mstate == MIdle) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_timeout"}, ok, 1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("init_busy", busy, 0);
        check("init_m_valid", m_valid, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic readout, latency and done timing
        do_start(12'h010, 4);
        wait_idle("t1", 40);
        check("t1_ren_n", ren_n, 4);
        check("t1_first_ren", first_ren, 1);
        check("t1_last_ren", last_ren, 4);
        check("t1_addr0", addr_log[0], 12'h010);
        check("t1_addr3", addr_log[3], 12'h013);
        check("t1_first_val", first_val, 3);
        check("t1_last_val", last_val, 6);
        check("t1_done_at", done_at, 7);
        check("t1_done_n", done_n, 1);

        // Address wrap at the top of the SRAM
        do_start(12'h3FE, 4);
        wait_idle("t2", 40);
        check("t2_addr0", addr_log[0], 12'h3FE);
        check("t2_addr1", addr_log[1], 12'h3FF);
        check("t2_addr2", addr_log[2], 12'h000);
        check("t2_addr3", addr_log[3], 12'h001);
        check("t2_xfer", st_xfer, 4);

        // Backpressure: random ready then a long stall
        do_start(12'h123, 8);
        for (int i = 0; i < 6; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        m_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1 m_ready = 1'b1;
        wait_idle("t3", 60);
        check("t3_max_out", max_out, 3);
        check("t3_ren_n", ren_n, 8);
        check("t3_xfer", st_xfer, 8);
        check("t3_done_n", done_n, 1);

        // Zero-length command
        do_start(12'h055, 0);
        wait_idle("t4", 10);
        check("t4_done_at", done_at, 1);
        check("t4_ren_n", ren_n, 0);
        check("t4_val_n", val_n, 0);
        check("t4_busy_seen", busy_seen, 0);

        // Abort in cycle 6, then a short command
        do_start(12'h200, 16);
        repeat (5) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("t5_busy_after_abort", busy, 0);
        check("t5_valid_after_abort", m_valid, 0);
        check("t5_xfer", st_xfer, 4);
        repeat (3) @(posedge clk);
        check("t5_done_n", done_n, 0);
        do_start(12'h300, 2);
        wait_idle("t5b", 20);
        check("t5b_xfer", st_xfer, 2);
        check("t5b_done_n", done_n, 1);

        // Asynchronous reset mid-readout
        do_start(12'h000, 1024);
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t6_async_busy", busy, 0);
        check("t6_async_ren", ren, 0);
        check("t6_async_valid", m_valid, 0);
        check("t6_async_rd_addr", rd_addr, 0);
        check("t6_async_m_data", m_data, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        do_start(12'h3FF, 3);
        wait_idle("t6b", 20);
        check("t6b_addr1", addr_log[1], 12'h000);
        check("t6b_xfer", st_xfer, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sram_rd_streamer.md
SRAM_RD_STREAMER -- requirements
Module: sram_rd_streamer

Interface
REQ-001 The block SHALL have parameter DATA_LEN, default 32, meaning the SRAM word and stream data width.
REQ-002 The block SHALL have parameter DEPTH, default 1024, meaning the SRAM depth in words.
REQ-003 The block SHALL have parameter ADDR_LEN, default $clog2(DEPTH), meaning the SRAM address width.
REQ-004 clk  input  1  single clock for all logic and the SRAM read port; one clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 start  input  1  one-cycle command strobe that begins a readout.
REQ-007 start_addr  input  ADDR_LEN  first word address, sampled with start.
REQ-008 length  input  ADDR_LEN+1  word count 0..DEPTH, sampled with start.
REQ-009 abort  input  1  terminates the current readout.
REQ-010 busy  output  1  high while a readout is in progress.
REQ-011 done  output  1  one-cycle pulse at normal completion.
REQ-012 ren  output  1  SRAM read enable.
REQ-013 rd_addr  output  ADDR_LEN  SRAM read address.
REQ-014 rd_data  input  DATA_LEN  SRAM registered read data, valid the cycle after ren.
REQ-015 m_valid  output  1  stream word available.
REQ-016 m_ready  input  1  stream consumer accepts word.
REQ-017 m_data  output  DATA_LEN  stream word.

Function
REQ-018 The block SHALL implement states IDLE, RUN, FIN: IDLE->RUN on start with length>0; IDLE->FIN on start with length==0; RUN->FIN on the handshake of the last word; FIN->IDLE unconditionally; RUN->IDLE on abort.
REQ-019 start SHALL be ignored outside IDLE; abort SHALL be ignored outside RUN.
REQ-020 busy SHALL equal (state==RUN); done SHALL equal (state==FIN), giving exactly one done cycle per completed command.
REQ-021 ren SHALL be high iff state==RUN, issued count < length, and (buffer occupancy + in-flight reads) < 3; ren SHALL have no combinational path from m_ready.
REQ-022 rd_addr SHALL be start_addr for the first read and increment by one per issued read, wrapping modulo DEPTH (DEPTH-1 -> 0).
REQ-023 The word on rd_data in the cycle after each ren SHALL be pushed into a 3-entry output FIFO in issue order.
REQ-024 m_valid SHALL be high iff the FIFO is non-empty; m_data SHALL be the FIFO head; a word is transferred when m_valid && m_ready; m_data SHALL be stable while m_valid && !m_ready.
REQ-025 Latency: start in cycle 0 -> ren in cycle 1 -> m_valid with word 0 in cycle 3.
REQ-026 With m_ready held high, the block SHALL sustain one word per cycle after the first.
REQ-027 Simultaneous FIFO push and pop SHALL leave occupancy unchanged; the FIFO SHALL never overflow under any m_ready pattern.
REQ-028 Exactly length words SHALL be issued and transferred per command; no extra ren beyond length.
REQ-029 On abort the block SHALL, at the next edge, enter IDLE, empty the FIFO, discard any in-flight read data, and not pulse done.
REQ-030 A new start accepted in the FIN or abort-return IDLE cycle boundary SHALL be honoured exactly as in IDLE (start in FIN is ignored).

Reset
REQ-031 While rst_n is low: state IDLE, busy=0, done=0, ren=0, rd_addr=0, m_valid=0, m_data=0, FIFO empty, counters 0.
REQ-032 Reset asserted mid-readout SHALL clear all state immediately without waiting for a clock; in-flight read data arriving after release SHALL be discarded.

Verification
REQ-033 start_addr=0x010, length=4, m_ready=1 -> ren cycles 1-4 with rd_addr 0x010..0x013; m_valid cycles 3-6 with those words; done pulse cycle 7.
REQ-034 start_addr=0x3FE, length=4, DEPTH=1024 -> rd_addr sequence 0x3FE, 0x3FF, 0x000, 0x001; 4 words in order.
REQ-035 length=8, m_ready toggling random/held low 10 cycles -> ren stops with occupancy+in-flight=3, m_data stable while stalled, all 8 words delivered once in order, done once.
REQ-036 length=0 -> no ren, no m_valid, done pulse in cycle 1, busy stays 0.
REQ-037 length=16, abort in cycle 6 -> IDLE next edge, m_valid=0, no done; following start length=2 delivers exactly 2 correct words.
REQ-038 rst_n low in mid-readout (length=1024) -> outputs to reset values asynchronously; after release, no ren or m_valid until a new start.
